// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the CPU run-control block: state encoding and default rate table.
package run_ctrl_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ENC_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ENC_RUN    = 3'd1;
  localparam logic [STATE_W-1:0] ENC_PAUSED = 3'd2;
  localparam logic [STATE_W-1:0] ENC_STEP   = 3'd3;
  localparam logic [STATE_W-1:0] ENC_HALTED = 3'd4;
  localparam logic [STATE_W-1:0] ENC_SRST   = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = ENC_IDLE,
    S_RUN    = ENC_RUN,
    S_PAUSED = ENC_PAUSED,
    S_STEP   = ENC_STEP,
    S_HALTED = ENC_HALTED,
    S_SRST   = ENC_SRST
  } runState_e;

  localparam int          DEF_NUM_RATES  = 4;
  localparam int          DEF_DIV_W      = 27;
  localparam int unsigned DEF_DEB_CYCLES = 1_000_000;
  localparam int          DEF_CNT_W      = 32;

  // Table is written slowest rate first: rate index 0 is the leftmost entry,
  // so index r lives at packed slot NUM_RATES-1-r.
  localparam logic [DEF_NUM_RATES-1:0][DEF_DIV_W-1:0] DEF_RATE_DIV =
    {27'd50_000_000, 27'd5_000_000, 27'd500_000, 27'd1};

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser followed by an independent debounce counter per bit.
module sw_debounce #(
  parameter int          WIDTH      = 1,
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic             clk_i,
  input  logic             rstN_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] deb_o
);

  localparam int            CW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [WIDTH-1:0]         meta_q;
  logic [WIDTH-1:0]         sync_q;
  logic [WIDTH-1:0]         deb_q;
  logic [WIDTH-1:0][CW-1:0] cnt_q;

  // Bring the asynchronous switch levels into the clk domain.
  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
    end
  end

  // A bit flips only after it has disagreed with the output for DEB_CYCLES samples in a row.
  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) begin
      deb_q <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          deb_q[i] <= sync_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run control: debounced switches drive a run/pause/step/halt FSM that
// issues single-cycle cpu_ce pulses at a selectable rate and counts them.
module cpu_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int                                NUM_RATES  = DEF_NUM_RATES,
  parameter int                                DIV_W      = DEF_DIV_W,
  parameter logic [NUM_RATES-1:0][DIV_W-1:0]   RATE_DIV   = DEF_RATE_DIV,
  parameter int unsigned                       DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int                                CNT_W      = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sw_start,
  input  logic                         sw_pause,
  input  logic                         sw_step,
  input  logic                         sw_srst,
  input  logic [$clog2(NUM_RATES)-1:0] sw_rate,
  input  logic                         cpu_halt,
  output logic                         cpu_ce,
  output logic                         cpu_rst,
  output logic [STATE_W-1:0]           run_state,
  output logic [CNT_W-1:0]             cycle_cnt
);

  localparam int RATE_W = $clog2(NUM_RATES);
  localparam int SW_W   = RATE_W + 4;

  logic [SW_W-1:0]   swDeb;
  logic              startDeb, pauseDeb, stepDeb, srstDeb;
  logic [RATE_W-1:0] rateDeb;
  logic              stepEdge, srstEdge;

  runState_e         state_q, state_d;
  logic [DIV_W-1:0]  divCnt_q, divCnt_d;
  logic [RATE_W-1:0] rateSel_q, rateSel_d;
  logic [CNT_W-1:0]  cycleCnt_q, cycleCnt_d;
  logic              srstCnt_q, srstCnt_d;
  logic              porRst_q;
  logic              stepPrev_q, srstPrev_q;

  logic [RATE_W-1:0] rateIdx;
  logic [DIV_W-1:0]  divLimit;
  logic              ceRun;

  sw_debounce #(
    .WIDTH      (SW_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) uDebounce (
    .clk_i  (clk),
    .rstN_i (rst),
    .raw_i  ({sw_rate, sw_srst, sw_step, sw_pause, sw_start}),
    .deb_o  (swDeb)
  );

  assign startDeb = swDeb[0];
  assign pauseDeb = swDeb[1];
  assign stepDeb  = swDeb[2];
  assign srstDeb  = swDeb[3];
  assign rateDeb  = swDeb[SW_W-1:4];

  assign stepEdge = stepDeb & ~stepPrev_q;
  assign srstEdge = srstDeb & ~srstPrev_q;

  assign rateIdx  = RATE_W'(NUM_RATES - 1) - rateSel_q;
  assign divLimit = RATE_DIV[rateIdx] - DIV_W'(1);
  // ">=" rather than "==" so a counter left above a smaller limit wraps immediately.
  assign ceRun    = (state_q == S_RUN) && (divCnt_q >= divLimit);

  assign cpu_rst   = porRst_q || (state_q == S_SRST);
  assign cpu_ce    = (ceRun || (state_q == S_STEP)) && !cpu_rst;
  assign run_state = state_q;
  assign cycle_cnt = cycleCnt_q;

  // Next-state, divider, rate sampling and cycle counter; soft reset overrides everything.
  always_comb begin
    state_d    = state_q;
    divCnt_d   = divCnt_q;
    rateSel_d  = rateSel_q;
    cycleCnt_d = cycleCnt_q;
    srstCnt_d  = 1'b0;

    if (cpu_ce && (cycleCnt_q != '1)) begin
      cycleCnt_d = cycleCnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        divCnt_d  = '0;
        rateSel_d = rateDeb;
        if (startDeb) begin
          state_d = pauseDeb ? S_PAUSED : S_RUN;
        end
      end
      S_RUN: begin
        if (cpu_ce) begin
          divCnt_d  = '0;
          rateSel_d = rateDeb;
        end else begin
          divCnt_d = divCnt_q + DIV_W'(1);
        end
        if (cpu_ce && cpu_halt) begin
          state_d = S_HALTED;
        end else if (pauseDeb) begin
          state_d = S_PAUSED;
        end else if (!startDeb) begin
          state_d = S_IDLE;
        end
      end
      S_PAUSED: begin
        if (!pauseDeb) begin
          state_d = startDeb ? S_RUN : S_IDLE;
        end else if (stepEdge) begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        state_d = (cpu_ce && cpu_halt) ? S_HALTED : S_PAUSED;
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      S_SRST: begin
        divCnt_d   = '0;
        cycleCnt_d = '0;
        rateSel_d  = rateDeb;
        if (srstCnt_q) begin
          state_d = S_IDLE;
        end else begin
          srstCnt_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (srstEdge) begin
      state_d    = S_SRST;
      srstCnt_d  = 1'b0;
      divCnt_d   = '0;
      cycleCnt_d = '0;
    end
  end

  // State and datapath registers; porRst_q holds cpu_rst for the first clk after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      divCnt_q   <= '0;
      rateSel_q  <= '0;
      cycleCnt_q <= '0;
      srstCnt_q  <= 1'b0;
      porRst_q   <= 1'b1;
      stepPrev_q <= 1'b0;
      srstPrev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      divCnt_q   <= divCnt_d;
      rateSel_q  <= rateSel_d;
      cycleCnt_q <= cycleCnt_d;
      srstCnt_q  <= srstCnt_d;
      porRst_q   <= 1'b0;
      stepPrev_q <= stepDeb;
      srstPrev_q <= srstDeb;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a 4-cycle debounce and divisors {8,4,2,1}.
// A raw switch change applied at a negedge is visible in run_state 7 negedges later
// (2 synchroniser flops, 4 debounce samples, 1 FSM edge).
module tb_cpu_run_ctrl;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RUN    = 3'd1;
  localparam logic [2:0] PAUSED = 3'd2;
  localparam logic [2:0] STEP   = 3'd3;
  localparam logic [2:0] HALTED = 3'd4;
  localparam logic [2:0] SRST   = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        sw_start, sw_pause, sw_step, sw_srst;
  logic [1:0]  sw_rate;
  logic        cpu_halt;
  logic        cpu_ce, cpu_rst;
  logic [2:0]  run_state;
  logic [31:0] cycle_cnt;

  int vecCount  = 0;
  int missCount = 0;
  int ceSeen    = 0;
  int leftIdle;

  cpu_run_ctrl #(
    .NUM_RATES  (4),
    .DIV_W      (27),
    .RATE_DIV   ({27'd8, 27'd4, 27'd2, 27'd1}),
    .DEB_CYCLES (4),
    .CNT_W      (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_start  (sw_start),
    .sw_pause  (sw_pause),
    .sw_step   (sw_step),
    .sw_srst   (sw_srst),
    .sw_rate   (sw_rate),
    .cpu_halt  (cpu_halt),
    .cpu_ce    (cpu_ce),
    .cpu_rst   (cpu_rst),
    .run_state (run_state),
    .cycle_cnt (cycle_cnt)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  // Drive all raw switches at once.
  task automatic applyStimulus(input logic st, input logic pa, input logic sp,
                               input logic sr, input logic [1:0] rt);
    sw_start = st;
    sw_pause = pa;
    sw_step  = sp;
    sw_srst  = sr;
    sw_rate  = rt;
  endtask

  // Advance to the n-th following negedge, counting cpu_ce pulses seen on the way.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (cpu_ce) ceSeen++;
    end
  endtask

  // Single comparison point: counts every vector and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    // Reset values while rst is held low.
    rst      = 1'b0;
    cpu_halt = 1'b0;
    applyStimulus(0, 0, 0, 0, 2'd0);
    tick(2);
    checkOutput("reset_ce", cpu_ce, 0);
    checkOutput("reset_cpu_rst", cpu_rst, 1);
    checkOutput("reset_state", run_state, IDLE);
    checkOutput("reset_cnt", cycle_cnt, 0);
    rst = 1'b1;
    #1 checkOutput("release_cpu_rst_held", cpu_rst, 1);
    tick(1);
    checkOutput("release_cpu_rst_drop", cpu_rst, 0);

    // Run at rate 1 (divide by 4): exact debounce latency, then a pulse every 4 clks.
    $display("[TB] run at rate 1");
    applyStimulus(1, 0, 0, 0, 2'd1);
    tick(6);
    checkOutput("deb_latency_idle", run_state, IDLE);
    tick(1);
    checkOutput("deb_latency_run", run_state, RUN);
    for (int k = 0; k < 40; k++) begin
      checkOutput($sformatf("rate1_ce_%0d", k), cpu_ce, ((k % 4) == 3) ? 1 : 0);
      tick(1);
    end
    checkOutput("rate1_cnt", cycle_cnt, 10);

    // Pause: RUN keeps dividing for 7 more cycles (one pulse), then three steps.
    $display("[TB] pause and step");
    applyStimulus(1, 1, 0, 0, 2'd1);
    tick(7);
    checkOutput("pause_state", run_state, PAUSED);
    checkOutput("pause_cnt", cycle_cnt, 11);
    ceSeen = 0;
    for (int s = 0; s < 3; s++) begin
      applyStimulus(1, 1, 1, 0, 2'd1);
      tick(7);
      checkOutput($sformatf("step%0d_state", s), run_state, STEP);
      checkOutput($sformatf("step%0d_ce", s), cpu_ce, 1);
      tick(1);
      checkOutput($sformatf("step%0d_back", s), run_state, PAUSED);
      applyStimulus(1, 1, 0, 0, 2'd1);
      tick(8);
    end
    checkOutput("step_pulses", ceSeen, 3);
    checkOutput("step_cnt", cycle_cnt, 14);
    checkOutput("step_final_state", run_state, PAUSED);

    // Resume with rate 0: held divider (3) still wraps on the old limit, then divide by 8.
    $display("[TB] resume with rate change");
    applyStimulus(1, 0, 0, 0, 2'd0);
    tick(7);
    checkOutput("resume_state", run_state, RUN);
    for (int k = 0; k < 9; k++) begin
      checkOutput($sformatf("rate0_ce_%0d", k), cpu_ce, (k == 0 || k == 8) ? 1 : 0);
      tick(1);
    end
    checkOutput("rate0_cnt", cycle_cnt, 16);

    // Soft reset mid-divide, start dropped at the same time: srst wins.
    $display("[TB] soft reset while running");
    applyStimulus(0, 0, 0, 1, 2'd0);
    tick(6);
    checkOutput("srst_pre_state", run_state, RUN);
    checkOutput("srst_pre_cnt", cycle_cnt, 16);
    tick(1);
    checkOutput("srst1_state", run_state, SRST);
    checkOutput("srst1_cpu_rst", cpu_rst, 1);
    checkOutput("srst1_ce", cpu_ce, 0);
    checkOutput("srst1_cnt", cycle_cnt, 0);
    tick(1);
    checkOutput("srst2_state", run_state, SRST);
    checkOutput("srst2_cpu_rst", cpu_rst, 1);
    checkOutput("srst2_ce", cpu_ce, 0);
    tick(1);
    checkOutput("srst_done_state", run_state, IDLE);
    checkOutput("srst_done_cpu_rst", cpu_rst, 0);
    tick(3);
    checkOutput("srst_idle_hold", run_state, IDLE);
    applyStimulus(0, 0, 0, 0, 2'd0);
    tick(8);

    // Halt at rate 3 (pulse every clk): halt retires with the 5th pulse.
    $display("[TB] halt");
    applyStimulus(1, 0, 0, 0, 2'd3);
    tick(7);
    checkOutput("halt_run_state", run_state, RUN);
    checkOutput("halt_first_ce", cpu_ce, 1);
    checkOutput("halt_first_cnt", cycle_cnt, 0);
    tick(4);
    checkOutput("halt_fifth_cnt", cycle_cnt, 4);
    checkOutput("halt_fifth_ce", cpu_ce, 1);
    cpu_halt = 1'b1;
    tick(1);
    checkOutput("halted_state", run_state, HALTED);
    checkOutput("halted_ce", cpu_ce, 0);
    checkOutput("halted_cnt", cycle_cnt, 5);
    cpu_halt = 1'b0;
    ceSeen   = 0;
    tick(10);
    checkOutput("halted_no_ce", ceSeen, 0);
    checkOutput("halted_hold_state", run_state, HALTED);
    checkOutput("halted_hold_cnt", cycle_cnt, 5);

    // Leave HALTED through soft reset; start still high so RUN follows IDLE.
    $display("[TB] halt exit via soft reset");
    applyStimulus(1, 0, 0, 1, 2'd3);
    tick(7);
    checkOutput("hexit_srst", run_state, SRST);
    tick(2);
    checkOutput("hexit_idle", run_state, IDLE);
    tick(1);
    checkOutput("hexit_run", run_state, RUN);
    checkOutput("hexit_ce", cpu_ce, 1);
    tick(3);

    // Asynchronous reset between clock edges while running.
    $display("[TB] async reset mid-run");
    #2 rst = 1'b0;
    #1;
    checkOutput("async_ce", cpu_ce, 0);
    checkOutput("async_cpu_rst", cpu_rst, 1);
    checkOutput("async_state", run_state, IDLE);
    checkOutput("async_cnt", cycle_cnt, 0);
    applyStimulus(0, 0, 0, 0, 2'd0);
    tick(1);
    rst = 1'b1;
    #1 checkOutput("async_release_held", cpu_rst, 1);
    tick(1);
    checkOutput("async_release_drop", cpu_rst, 0);
    checkOutput("async_release_state", run_state, IDLE);
    tick(8);

    // Start pulses shorter than the debounce window must be ignored.
    $display("[TB] debounce glitches");
    for (int w = 2; w <= 3; w++) begin
      applyStimulus(1, 0, 0, 0, 2'd0);
      tick(w);
      applyStimulus(0, 0, 0, 0, 2'd0);
      leftIdle = 0;
      for (int i = 0; i < 12; i++) begin
        tick(1);
        if (run_state != IDLE) leftIdle = 1;
      end
      checkOutput($sformatf("glitch%0d_no_change", w), leftIdle, 0);
    end

    // A pulse exactly the debounce length is accepted, and its release is too.
    applyStimulus(1, 0, 0, 0, 2'd0);
    tick(4);
    applyStimulus(0, 0, 0, 0, 2'd0);
    tick(3);
    checkOutput("deb_exact_run", run_state, RUN);
    tick(3);
    checkOutput("deb_exact_still_run", run_state, RUN);
    tick(1);
    checkOutput("deb_exact_idle", run_state, IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
